// File: rtl/image_link_pkg.sv
// Shared constants and state encodings for the serial pixel link (send and receive paths).
package image_link_pkg;

  localparam int PIXEL_W = 12;
  localparam int ADDR_W  = 17;
  localparam int BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] HI_NIBBLE_MASK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    PIX_WAIT_HI,
    PIX_WAIT_LO,
    PIX_DONE
  } pix_state_t;

endpackage

// File: rtl/uart_byte_receiver.sv
// 8N1 byte deserialiser: synchronises the line, samples mid-bit, flags a bad stop bit.
module uart_byte_receiver
  import image_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_in,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              framing_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t         state, state_nxt;
  logic [1:0]        sync;
  logic              rx;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              cnt_clr;
  logic              sample_bit;
  logic              stop_sample;

  assign rx = sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cnt_clr     = 1'b0;
    sample_bit  = 1'b0;
    stop_sample = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_clr = 1'b1;
        if (!rx) state_nxt = RX_START;
      end
      RX_START: begin
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (clk_cnt == HALF_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_clr    = 1'b1;
          sample_bit = 1'b1;
          if (bit_idx == 3'd7) state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_cnt == BIT_LAST) begin
          cnt_clr     = 1'b1;
          stop_sample = 1'b1;
          state_nxt   = RX_IDLE;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync        <= 2'b11;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      sync        <= {sync[0], uart_in};
      clk_cnt     <= cnt_clr ? '0 : clk_cnt + 1'b1;
      byte_valid  <= stop_sample && rx;
      framing_err <= stop_sample && !rx;
      if (state == RX_IDLE) bit_idx <= '0;
      if (sample_bit) begin
        shreg   <= {rx, shreg[BYTE_W-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_sample && rx) byte_data <= shreg;
    end
  end

endmodule

// File: rtl/image_receiver.sv
// Rebuilds 12-bit pixels from hi/lo UART byte pairs and writes them to a frame buffer port.
// Counts framing, sync and inter-byte gap errors; start re-arms for the next frame.
module image_receiver
  import image_link_pkg::*;
#(
  parameter int NUM_PIXELS       = 100,
  parameter int CLK_FREQ         = 50_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int GAP_TIMEOUT_CLKS = 4 * (CLK_FREQ / BAUD_RATE) * 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_in,
  input  logic               start,
  output logic [ADDR_W-1:0]  address,
  output logic               wr_en,
  output logic [PIXEL_W-1:0] wr_data,
  output logic               image_ready,
  output logic [7:0]         error_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int GAP_W        = $clog2(GAP_TIMEOUT_CLKS + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TIMEOUT_CLKS - 1);

  logic              byte_valid;
  logic [BYTE_W-1:0] byte_data;
  logic              framing_err;

  pix_state_t        pix_state, pix_nxt;
  logic [3:0]        hi_nibble;
  logic [GAP_W-1:0]  gap_cnt;
  logic              do_write;
  logic              latch_hi;
  logic              err_evt;

  uart_byte_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .uart_in     (uart_in),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .framing_err (framing_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_state <= PIX_WAIT_HI;
    else     pix_state <= pix_nxt;
  end

  always_comb begin
    pix_nxt  = pix_state;
    do_write = 1'b0;
    latch_hi = 1'b0;
    err_evt  = 1'b0;
    case (pix_state)
      PIX_WAIT_HI: begin
        if (framing_err) begin
          err_evt = 1'b1;
        end else if (byte_valid) begin
          if ((byte_data & HI_NIBBLE_MASK) != '0) begin
            err_evt = 1'b1;
          end else begin
            latch_hi = 1'b1;
            pix_nxt  = PIX_WAIT_LO;
          end
        end
      end
      PIX_WAIT_LO: begin
        if (framing_err) begin
          err_evt = 1'b1;
          pix_nxt = PIX_WAIT_HI;
        end else if (byte_valid) begin
          do_write = 1'b1;
          pix_nxt  = (address == LAST_ADDR) ? PIX_DONE : PIX_WAIT_HI;
        end else if (gap_cnt == GAP_LAST) begin
          err_evt = 1'b1;
          pix_nxt = PIX_WAIT_HI;
        end
      end
      PIX_DONE: pix_nxt = PIX_DONE;
      default:  pix_nxt = PIX_WAIT_HI;
    endcase
    // A start pulse overrides everything, including a lo byte arriving this cycle.
    if (start) begin
      pix_nxt  = PIX_WAIT_HI;
      do_write = 1'b0;
      latch_hi = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_nibble   <= '0;
      gap_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      address     <= '0;
      image_ready <= 1'b0;
      error_count <= '0;
    end else begin
      wr_en <= do_write;
      if (latch_hi) hi_nibble <= byte_data[3:0];
      if (do_write) wr_data <= {hi_nibble, byte_data};
      if (pix_state != PIX_WAIT_LO || byte_valid) gap_cnt <= '0;
      else                                        gap_cnt <= gap_cnt + 1'b1;
      // Address advances the cycle after the strobe so it names the written slot during wr_en.
      if (start) begin
        address     <= '0;
        image_ready <= 1'b0;
      end else if (wr_en) begin
        address <= address + 1'b1;
        if (address == LAST_ADDR) image_ready <= 1'b1;
      end
      if (err_evt && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_image_receiver.sv
// Randomised bench for image_receiver: serialises byte pairs and scores writes against a pixel-level model.
module tb_image_receiver;

  localparam int NP  = 4;
  localparam int CF  = 1_000_000;
  localparam int BR  = 100_000;
  localparam int CPB = CF / BR;
  localparam int GAP = 4 * CPB * 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_in;
  logic        start;
  logic [16:0] address;
  logic        wr_en;
  logic [11:0] wr_data;
  logic        image_ready;
  logic [7:0]  error_count;

  always #5 clk = ~clk;

  image_receiver #(
    .NUM_PIXELS(NP), .CLK_FREQ(CF), .BAUD_RATE(BR), .GAP_TIMEOUT_CLKS(GAP)
  ) dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .start(start),
    .address(address), .wr_en(wr_en), .wr_data(wr_data),
    .image_ready(image_ready), .error_count(error_count)
  );

  int total = 0;
  int bad   = 0;

  logic [28:0] obs_q[$];
  logic [28:0] exp_q[$];
  logic [28:0] o, e;
  int          e0;

  bit          m_lo;
  logic [3:0]  m_hi;
  int          m_addr;
  bit          m_ready;
  int          m_err;

  task automatic tick();
    @(posedge clk);
    #1;
    if (wr_en === 1'b1) obs_q.push_back({address, wr_data});
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit ok, input bit long_gap);
    if (m_ready) return;
    if (long_gap && m_lo) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      m_lo  = 0;
    end
    if (!ok) begin
      m_err = (m_err < 255) ? m_err + 1 : 255;
      m_lo  = 0;
      return;
    end
    if (!m_lo) begin
      if (b[7:4] != 4'h0) m_err = (m_err < 255) ? m_err + 1 : 255;
      else begin
        m_hi = b[3:0];
        m_lo = 1;
      end
    end else begin
      exp_q.push_back({17'(m_addr), m_hi, b});
      m_addr++;
      m_lo = 0;
      if (m_addr == NP) m_ready = 1;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit ok, input bit long_gap);
    if (long_gap) idle(GAP + 100);
    model_byte(b, ok, long_gap);
    uart_in = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      idle(CPB);
    end
    uart_in = ok;
    idle(CPB);
    uart_in = 1'b1;
    idle($urandom_range(0, 20));
  endtask

  task automatic tx_pixel(input logic [11:0] p);
    tx_byte({4'h0, p[11:8]}, 1'b1, 1'b0);
    tx_byte(p[7:0], 1'b1, 1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr  = 0;
    m_ready = 0;
    m_lo    = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_in = 1'b1; start = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(5);
    uart_in = 1'b0;
    idle(CPB + CPB / 2 + 30);
    rst = 1'b1;
    idle(2);
    total++;
    if ({address, wr_en, wr_data, image_ready, error_count} !== 39'd0) begin
      bad++;
      $display("FAIL reset_in: addr=%0d wr_en=%b data=%h ready=%b err=%0d, want all 0",
               address, wr_en, wr_data, image_ready, error_count);
    end
    rst = 1'b0;
    tick();
    uart_in = 1'b1;
    idle(40);
    m_lo = 0; m_addr = 0; m_ready = 0; m_err = 0;
    obs_q.delete(); exp_q.delete();
    total++;
    if ({address, wr_en, wr_data, image_ready, error_count} !== 39'd0) begin
      bad++;
      $display("FAIL reset_out: addr=%0d wr_en=%b data=%h ready=%b err=%0d, want all 0",
               address, wr_en, wr_data, image_ready, error_count);
    end
    tx_byte(8'h0A, 1'b1, 1'b0);
    tx_byte(8'hBC, 1'b1, 1'b0);
    idle(30);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {17'd0, 12'hABC}) begin
      bad++;
      $display("FAIL reset_first_pixel: got %0d writes, first=%h, want one write addr 0 data abc",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 29'h0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_full_frame();
    pulse_start();
    tx_pixel(12'h123);
    tx_pixel(12'h456);
    tx_pixel(12'h789);
    tx_pixel(12'hFFF);
    idle(30);
    total++;
    if (obs_q.size() != exp_q.size() || exp_q.size() != NP) begin
      bad++;
      $display("FAIL frame_count: got %0d writes, want %0d", obs_q.size(), NP);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL frame_write: got addr=%0d data=%h, want addr=%0d data=%h",
                 o[28:12], o[11:0], e[28:12], e[11:0]);
      end
    end
    total++;
    if (image_ready !== 1'b1 || address !== 17'd4) begin
      bad++;
      $display("FAIL frame_ready: ready=%b addr=%0d, want ready=1 addr=4", image_ready, address);
    end
    obs_q.delete(); exp_q.delete();
    tx_pixel(12'($urandom));
    idle(30);
    total++;
    if (obs_q.size() != 0 || image_ready !== 1'b1 || address !== 17'd4) begin
      bad++;
      $display("FAIL frame_extra: writes=%0d ready=%b addr=%0d, want 0 writes ready=1 addr=4",
               obs_q.size(), image_ready, address);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_sync_error();
    pulse_start();
    e0 = int'(error_count);
    tx_byte(8'h5A, 1'b1, 1'b0);
    tx_pixel(12'h321);
    idle(30);
    total++;
    if (int'(error_count) - e0 != 1 || int'(error_count) != m_err) begin
      bad++;
      $display("FAIL sync_errcnt: got %0d, want %0d", error_count, e0 + 1);
    end
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {17'd0, 12'h321}) begin
      bad++;
      $display("FAIL sync_write: got %0d writes, first=%h, want one write addr 0 data 321",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 29'h0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gap_timeout();
    pulse_start();
    e0 = int'(error_count);
    tx_byte(8'h07, 1'b1, 1'b0);
    tx_byte(8'h01, 1'b1, 1'b1);
    tx_byte(8'h02, 1'b1, 1'b0);
    idle(30);
    total++;
    if (int'(error_count) - e0 != 1 || int'(error_count) != m_err) begin
      bad++;
      $display("FAIL gap_errcnt: got %0d, want %0d", error_count, e0 + 1);
    end
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {17'd0, 12'h102}) begin
      bad++;
      $display("FAIL gap_write: got %0d writes, first=%h, want one write addr 0 data 102",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 29'h0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    pulse_start();
    e0 = int'(error_count);
    tx_byte(8'h0A, 1'b1, 1'b0);
    tx_byte(8'h55, 1'b0, 1'b0);
    idle(30);
    total++;
    if (obs_q.size() != 0 || int'(error_count) - e0 != 1) begin
      bad++;
      $display("FAIL framing_err: writes=%0d errcnt=%0d, want 0 writes errcnt=%0d",
               obs_q.size(), error_count, e0 + 1);
    end
    tx_pixel(12'hBCD);
    idle(30);
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== {17'd0, 12'hBCD}) begin
      bad++;
      $display("FAIL framing_recover: got %0d writes, first=%h, want one write addr 0 data bcd",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 29'h0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int kind;
    pulse_start();
    for (int k = 0; k < 12 && !m_ready; k++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        tx_byte({4'($urandom_range(1, 15)), 4'($urandom)}, 1'b1, 1'b0);
      end else if (kind == 1) begin
        tx_byte({4'h0, 4'($urandom)}, 1'b1, 1'b0);
        tx_byte(8'($urandom), 1'b0, 1'b0);
      end else begin
        tx_pixel(12'($urandom));
      end
    end
    idle(30);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count: got %0d writes, want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rand_write: got addr=%0d data=%h, want addr=%0d data=%h",
                 o[28:12], o[11:0], e[28:12], e[11:0]);
      end
    end
    total++;
    if (int'(error_count) != m_err || image_ready !== m_ready || int'(address) != m_addr) begin
      bad++;
      $display("FAIL rand_state: err=%0d ready=%b addr=%0d, want err=%0d ready=%b addr=%0d",
               error_count, image_ready, address, m_err, m_ready, m_addr);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch_restart();
    pulse_start();
    e0 = int'(error_count);
    uart_in = 1'b0;
    idle(3);
    uart_in = 1'b1;
    idle(60);
    total++;
    if (obs_q.size() != 0 || int'(error_count) != e0) begin
      bad++;
      $display("FAIL glitch: writes=%0d errcnt=%0d, want 0 writes errcnt=%0d",
               obs_q.size(), error_count, e0);
    end
    for (int k = 0; k < NP; k++) tx_pixel(12'($urandom));
    idle(30);
    total++;
    if (obs_q.size() != exp_q.size() || image_ready !== 1'b1) begin
      bad++;
      $display("FAIL restart_frame: writes=%0d ready=%b, want %0d writes ready=1",
               obs_q.size(), image_ready, exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL restart_write: got addr=%0d data=%h, want addr=%0d data=%h",
                 o[28:12], o[11:0], e[28:12], e[11:0]);
      end
    end
    pulse_start();
    total++;
    if (address !== 17'd0 || image_ready !== 1'b0 || int'(error_count) != e0) begin
      bad++;
      $display("FAIL restart_start: addr=%0d ready=%b errcnt=%0d, want addr=0 ready=0 errcnt=%0d",
               address, image_ready, error_count, e0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    uart_in = 1'b1;
    start   = 1'b0;
    test_reset();
    test_full_frame();
    test_sync_error();
    test_gap_timeout();
    test_framing();
    test_random();
    test_glitch_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART-side receiver that reconstructs a 12-bit pixel stream, the inverse of the image send path.
- Deserialises 8N1 bytes from a serial line and pairs them into 12-bit pixels.
- Writes each pixel into a frame-buffer write port at incrementing addresses.
- Flags image_ready once NUM_PIXELS pixels have landed.
- Sits between the board RX pin and the frame RAM; re-armed by a start pulse for each new frame.

Parameters:
- NUM_PIXELS, 100, pixels per frame; must be ≤ 2^17.
- CLK_FREQ, 50_000_000, system clock in Hz.
- BAUD_RATE, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division).
- GAP_TIMEOUT_CLKS, 4*CLKS_PER_BIT*10, maximum idle clocks allowed between the hi and lo byte of one pixel.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- uart_in  in  1  serial line, idle high, asynchronous to clk
- start  in  1  one-cycle pulse: clear address and image_ready, arm for a new frame
- address  out  17  write address of the next pixel
- wr_en  out  1  one-cycle frame-buffer write strobe
- wr_data  out  12  pixel written when wr_en=1
- image_ready  out  1  high once NUM_PIXELS pixels have been written
- error_count  out  8  saturating count of framing, sync and gap errors

Behaviour:
- Clocking and reset: one clock, asynchronous active-high reset.
  - Reset values: address=0, wr_en=0, wr_data=0, image_ready=0, error_count=0.
  - The 2-flop uart_in synchroniser resets to 1. Both FSMs reset to their idle states.
- Wire format: each pixel is two 8N1 bytes, LSB-first, hi byte then lo byte.
  - hi byte = {4'b0000, pixel[11:8]}.
  - lo byte = pixel[7:0].
- Byte RX FSM (IDLE, START, DATA, STOP), driven by the synchronised line:
  - IDLE: wait for rx_sync==0.
  - START: wait CLKS_PER_BIT/2 clocks. If the line is still 0, go to DATA; else treat as a glitch and return to IDLE (no error counted).
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. If 1, pulse byte_valid for one cycle with the byte. If 0, pulse framing_err and discard the byte.
  - After STOP, return to IDLE.
- Pixel FSM (WAIT_HI, WAIT_LO, DONE):
  - WAIT_HI, on byte_valid:
    - byte[7:4]≠0 → sync error (count++), stay in WAIT_HI.
    - Otherwise latch the nibble and go to WAIT_LO.
  - WAIT_LO:
    - A gap counter clears on entry and on each byte_valid. Reaching GAP_TIMEOUT_CLKS → count++, go to WAIT_HI.
    - framing_err → count++, go to WAIT_HI.
    - On byte_valid: next cycle wr_en=1, wr_data={hi,byte}, with address holding the written location during the strobe.
    - address increments on the cycle after wr_en.
    - If the written address was NUM_PIXELS-1, go to DONE and set image_ready=1 in the same cycle address becomes NUM_PIXELS. Otherwise go to WAIT_HI.
  - DONE: bytes are still received but discarded; no writes, no errors counted. address holds NUM_PIXELS; image_ready stays 1.
- framing_err in WAIT_HI or DONE: counted in WAIT_HI only.
- start, from any state: next cycle address=0, image_ready=0, pixel FSM → WAIT_HI.
  - error_count is preserved; it clears only on reset.
  - The byte RX FSM is not disturbed.
- Simultaneous events:
  - start in the same cycle as a lo-byte byte_valid: start wins; no write, byte dropped.
  - start in the same cycle as a pending wr_en: the write completes, then address is cleared.
- error_count saturates at 255.
- Latency: wr_en asserts 1 cycle after byte_valid of the lo byte. byte_valid asserts about 9.5 bit times plus 2 clocks after the start-bit falling edge.

Decomposition:
- Package image_link_pkg holds:
  - PIXEL_W=12, ADDR_W=17, BYTE_W=8
  - rx_state_t and pix_state_t enums
  - HI_NIBBLE_MASK=8'hF0
- The pixel_sender path shares these constants.
- Sub-module uart_byte_receiver:
  - Contains the synchroniser, the byte RX FSM and the bit counters.
  - Outputs byte_valid, byte_data and framing_err.
- Pixel assembly, gap timer, address and error counter stay in image_receiver.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000 → 10 clk/bit, NUM_PIXELS=4):
- Reset mid-byte (rx low in DATA), then release → all outputs 0; the next clean byte pair 0x0A,0xBC writes 12'hABC at address 0.
- Send 4 pixels 0x123,0x456,0x789,0xFFF → 4 wr_en pulses at addresses 0..3 with correct data; image_ready=1 with address=4; a 5th pixel produces no wr_en.
- Hi byte 0x5A (bad nibble), then pair 0x03,0x21 → error_count=1; single write of 12'h321 at address 0.
- Hi byte 0x07, idle past GAP_TIMEOUT_CLKS, then pair 0x01,0x02 → error_count=1; write 12'h102 at address 0.
- Stop bit forced 0 on the lo byte → error_count=1, no write, FSM in WAIT_HI; the following clean pair writes at address 0.
- 3-clock low glitch on uart_in → no byte_valid, no error. Then, after image_ready, start pulse → address=0, image_ready=0, error_count unchanged.
